// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-VC circular flit FIFOs with packet-framing checks and a registered, arbiter-granted output stage
//   clk, rst (async, active-high)
//   valid_i, vc_i, head_i, tail_i, flit_i : upstream flit
//   requests_o / grants_i                 : per-VC request to / grant from the downstream arbiter
//   valid_o, vc_o, flit_o, head_o, tail_o : registered output flit, one cycle after its grant
//   credit_o                              : per-VC credit pulse, aligned with valid_o
//   err_o                                 : sticky protocol / overflow / multi-grant error
module input_vc_buffer #(
  parameter int VC_NUM       = 2,
  parameter int BUFFER_DEPTH = 4,
  parameter int FLIT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  input  logic [$clog2(VC_NUM)-1:0] vc_i,
  input  logic                      head_i,
  input  logic                      tail_i,
  input  logic [FLIT_W-1:0]         flit_i,
  output logic [VC_NUM-1:0]         requests_o,
  input  logic [VC_NUM-1:0]         grants_i,
  output logic                      valid_o,
  output logic [$clog2(VC_NUM)-1:0] vc_o,
  output logic [FLIT_W-1:0]         flit_o,
  output logic                      head_o,
  output logic                      tail_o,
  output logic [VC_NUM-1:0]         credit_o,
  output logic                      err_o
);
  localparam int VW = $clog2(VC_NUM);
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int EW = FLIT_W + 2;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t          state [VC_NUM];
  logic [PW-1:0]   rptr  [VC_NUM];
  logic [PW-1:0]   wptr  [VC_NUM];
  logic [PW:0]     count [VC_NUM];
  logic [EW-1:0]   mem   [VC_NUM][BUFFER_DEPTH];
  logic            multi, pop_any, proto_err, full, push;
  logic [VW-1:0]   gidx;
  logic [VC_NUM-1:0] pop, psh;
  always_comb begin
    multi = |(grants_i & (grants_i - 1'b1));
    gidx = '0;
    pop = '0;
    requests_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (grants_i[v]) gidx = VW'(v);
      pop[v] = grants_i[v] && !multi && count[v] != '0;
      requests_o[v] = count[v] != '0;
    end
    pop_any = |pop;
    proto_err = valid_i && (state[vc_i] == IDLE ? !head_i : head_i);
    // a pop on the same VC this cycle frees the slot, so a full VC can still accept
    full = count[vc_i] == (PW+1)'(BUFFER_DEPTH) && !pop[vc_i];
    push = valid_i && !proto_err && !full;
    psh = '0;
    for (int v = 0; v < VC_NUM; v++) psh[v] = push && vc_i == VW'(v);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rptr[v]  <= '0;
        wptr[v]  <= '0;
        count[v] <= '0;
        state[v] <= IDLE;
      end
      valid_o  <= 1'b0;
      credit_o <= '0;
      err_o    <= 1'b0;
      vc_o     <= '0;
      flit_o   <= '0;
      head_o   <= 1'b0;
      tail_o   <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        rptr[v]  <= rptr[v] + PW'(pop[v]);
        wptr[v]  <= wptr[v] + PW'(psh[v]);
        count[v] <= count[v] + (PW+1)'(psh[v]) - (PW+1)'(pop[v]);
        if (psh[v]) state[v] <= tail_i ? IDLE : ACTIVE;
      end
      valid_o  <= pop_any;
      credit_o <= pop;
      err_o    <= err_o | (valid_i && !push) | multi;
      if (pop_any) begin
        {head_o, tail_o, flit_o} <= mem[gidx][rptr[gidx]];
        vc_o <= gidx;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[vc_i][wptr[vc_i]] <= {head_i, tail_i, flit_i};
endmodule
